// File: rtl/sbox_2om_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sbox_2om_scheduler_if
// Brief    : Requester / PRNG / S-box / response bundle for the S-box scheduler
// Revision : 1.0
// ============================================================================
interface sbox_2om_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int RAND_W = 24
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*24-1:0] req_sh;
    logic [N_REQ-1:0]    req_ready;
    logic                rnd_valid;
    logic [RAND_W-1:0]   rnd_data;
    logic                rnd_ready;
    logic [23:0]         sb_sh;
    logic [RAND_W-1:0]   sb_r;
    logic [23:0]         sb_res;
    logic [N_REQ-1:0]    rsp_valid;
    logic [23:0]         rsp_sh;
    logic                drain_req;
    logic                drain_done;
    logic                busy;

    modport slave (
        input  req_valid, req_sh, rnd_valid, rnd_data, sb_res, drain_req,
        output req_ready, rnd_ready, sb_sh, sb_r, rsp_valid, rsp_sh, drain_done, busy
    );

    modport master (
        output req_valid, req_sh, rnd_valid, rnd_data, sb_res, drain_req,
        input  req_ready, rnd_ready, sb_sh, sb_r, rsp_valid, rsp_sh, drain_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/sbox_2om_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sbox_2om_scheduler
// Brief    : Round-robin sharing of one pipelined 3-share masked AES S-box
// Revision : 1.0
// ============================================================================
module sbox_2om_scheduler #(
    parameter int N_REQ  = 4,
    parameter int LAT    = 6,
    parameter int RAND_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    sbox_2om_scheduler_if.slave bus
);
    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_SW  = 24;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [c_IDW-1:0] r_ptr;
    logic [LAT-1:0]   r_pv;
    logic [c_IDW-1:0] r_pid [LAT];

    logic             w_found;
    logic [c_IDW-1:0] w_win;
    logic [c_IDW:0]   w_sum;
    logic             w_gnt;
    logic [c_IDW-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] w_one;

    // Cyclic search starting at the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_IDW+1)'(k);
            if (w_sum >= (c_IDW+1)'(N_REQ))
                w_sum = w_sum - (c_IDW+1)'(N_REQ);
            if (!w_found && bus.req_valid[w_sum[c_IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_IDW-1:0];
            end
        end
    end

    // Reset gates the grant so no share value reaches the S-box while held in reset
    assign w_gnt     = rst_n && (r_state == ST_RUN) && !bus.drain_req && bus.rnd_valid && w_found;
    assign w_ptr_nxt = (w_win == c_IDW'(N_REQ-1)) ? '0 : w_win + 1'b1;
    assign w_one     = {{(N_REQ-1){1'b0}}, 1'b1};

    assign bus.req_ready  = w_gnt ? (w_one << w_win) : '0;
    assign bus.rnd_ready  = w_gnt;
    assign bus.sb_sh      = w_gnt ? bus.req_sh[c_SW*w_win +: c_SW] : '0;
    assign bus.sb_r       = w_gnt ? bus.rnd_data : '0;
    assign bus.rsp_valid  = r_pv[LAT-1] ? (w_one << r_pid[LAT-1]) : '0;
    assign bus.rsp_sh     = r_pv[LAT-1] ? bus.sb_res : '0;
    assign bus.busy       = |r_pv;
    assign bus.drain_done = (r_state == ST_DRAIN) && !(|r_pv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_ptr   <= '0;
            r_pv    <= '0;
            for (int k = 0; k < LAT; k++)
                r_pid[k] <= '0;
        end else begin
            if (r_state == ST_RUN) begin
                if (bus.drain_req)
                    r_state <= ST_DRAIN;
            end else if (!bus.drain_req) begin
                r_state <= ST_RUN;
            end

            if (w_gnt)
                r_ptr <= w_ptr_nxt;

            // Owner tracking mirrors the S-box latency stage for stage
            r_pv[0]  <= w_gnt;
            r_pid[0] <= w_win;
            for (int k = 1; k < LAT; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
            end
        end
    end
endmodule
`default_nettype wire
